spi_responder: RTL and testbench

- SPI mode-0 responder (slave) holding a NUM_REGS x 8-bit register file, addressed by an external SPI initiator over the Arduino-header SPI pins.
- It is the far end of the Nios SPI master protocol. The NIOS/initiator side writes and reads bytes; FPGA fabric (game/display logic) reads the registers and may also write them.
- All SPI inputs are oversampled in the Clk domain; no logic is clocked by SCLK.

---
 rtl/spi_responder_if.sv | 29 ++
 rtl/spi_responder.sv | 189 ++++++++++++++++++
 tb/tb_spi_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_responder_if.sv
// Pin and fabric-side signal bundle for spi_responder.
// The initiator/fabric side uses the master modport and the responder uses the slave modport.
interface spi_responder_if #(
  parameter int ADDR_W = 4
);
  logic              SCLK;
  logic              CS_N;
  logic              MOSI;
  logic              MISO;
  logic              MISO_OE;
  logic              busy;
  logic              wr_pulse;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;

  modport slave (
    input  SCLK, CS_N, MOSI, host_we, host_addr, host_wdata,
    output MISO, MISO_OE, busy, wr_pulse, wr_addr, wr_data, host_rdata
  );

  modport master (
    output SCLK, CS_N, MOSI, host_we, host_addr, host_wdata,
    input  MISO, MISO_OE, busy, wr_pulse, wr_addr, wr_data, host_rdata
  );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 responder with a small byte register file shared with the fabric.
// All SPI pins are oversampled in the Clk domain; nothing runs on SCLK.
module spi_responder #(
  parameter int          NUM_REGS = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_BYTE  = 8'h5A
) (
  input  logic           Clk,
  input  logic           Reset_n,
  spi_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  state_t            r_state;
  logic              r_sclkMeta, r_sclkSync, r_sclkPrev;
  logic              r_csMeta, r_csSync, r_csPrev;
  logic              r_mosiMeta, r_mosiSync, r_mosiPrev;
  logic [2:0]        r_bitCnt;
  logic [6:0]        r_rxShift;
  logic [7:0]        r_txShift;
  logic              r_rw;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic              r_miso;
  logic              r_misoOe;
  logic              r_wrPulse;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [7:0]        r_wrData;
  logic [7:0]        r_regs [NUM_REGS];

  logic              w_sclkRise, w_sclkFall, w_csRise, w_csFall;
  logic [7:0]        w_rxByte;
  logic              w_byteDone;
  logic [ADDR_W-1:0] w_cmdAddr;
  logic              w_cmdOor;
  logic [ADDR_W-1:0] w_addrNext;
  logic [7:0]        w_cmdLoad;
  logic [7:0]        w_dataLoad;
  logic              w_spiWe;

  // Idle levels are preset so that releasing reset never looks like an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sclkMeta <= 1'b0;
      r_sclkSync <= 1'b0;
      r_sclkPrev <= 1'b0;
      r_csMeta   <= 1'b1;
      r_csSync   <= 1'b1;
      r_csPrev   <= 1'b1;
      r_mosiMeta <= 1'b0;
      r_mosiSync <= 1'b0;
      r_mosiPrev <= 1'b0;
    end else begin
      r_sclkMeta <= bus.SCLK;
      r_sclkSync <= r_sclkMeta;
      r_sclkPrev <= r_sclkSync;
      r_csMeta   <= bus.CS_N;
      r_csSync   <= r_csMeta;
      r_csPrev   <= r_csSync;
      r_mosiMeta <= bus.MOSI;
      r_mosiSync <= r_mosiMeta;
      r_mosiPrev <= r_mosiSync;
    end
  end

  assign w_sclkRise = r_sclkSync & ~r_sclkPrev;
  assign w_sclkFall = ~r_sclkSync & r_sclkPrev;
  assign w_csRise   = r_csSync & ~r_csPrev;
  assign w_csFall   = ~r_csSync & r_csPrev;

  assign w_rxByte   = {r_rxShift, r_mosiSync};
  assign w_byteDone = w_sclkRise && (r_bitCnt == 3'd7);
  assign w_cmdAddr  = w_rxByte[ADDR_W-1:0];
  assign w_cmdOor   = |w_rxByte[6:ADDR_W];
  assign w_addrNext = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_cmdLoad  = (w_rxByte[7] && !w_cmdOor) ? r_regs[w_cmdAddr] : 8'h00;
  assign w_dataLoad = r_oor ? 8'h00 : r_regs[w_addrNext];

  // A chip-select rise in the same cycle aborts the byte, so it suppresses the write.
  assign w_spiWe = (r_state == ST_DATA) && !w_csRise && w_byteDone && !r_rw && !r_oor;

  // Host write first, SPI write second: on an address collision the SPI byte wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (bus.host_we) begin
        r_regs[bus.host_addr] <= bus.host_wdata;
      end
      if (w_spiWe) begin
        r_regs[r_addr] <= w_rxByte;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= 3'd0;
      r_rxShift <= 7'd0;
      r_txShift <= 8'h00;
      r_rw      <= 1'b0;
      r_oor     <= 1'b0;
      r_addr    <= '0;
      r_miso    <= 1'b0;
      r_misoOe  <= 1'b0;
      r_wrPulse <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= 8'h00;
    end else begin
      r_wrPulse <= 1'b0;
      if (w_spiWe) begin
        r_wrPulse <= 1'b1;
        r_wrAddr  <= r_addr;
        r_wrData  <= w_rxByte;
      end

      case (r_state)
        ST_IDLE: begin
          r_misoOe <= 1'b0;
          if (w_csFall) begin
            r_bitCnt  <= 3'd0;
            r_txShift <= ID_BYTE;
            r_miso    <= ID_BYTE[7];
            r_misoOe  <= 1'b1;
            r_state   <= ST_CMD;
          end
        end

        ST_CMD, ST_DATA: begin
          if (w_csRise) begin
            r_state  <= ST_IDLE;
            r_misoOe <= 1'b0;
            r_miso   <= 1'b0;
          end else begin
            if (w_sclkRise) begin
              r_rxShift <= w_rxByte[6:0];
              r_bitCnt  <= r_bitCnt + 3'd1;
            end
            // The fall after a byte's last rise must keep the freshly loaded MSB on MISO.
            if (w_sclkFall && (r_bitCnt != 3'd0)) begin
              r_txShift <= {r_txShift[6:0], 1'b0};
              r_miso    <= r_txShift[6];
            end
            if (w_byteDone) begin
              if (r_state == ST_CMD) begin
                r_rw      <= w_rxByte[7];
                r_addr    <= w_cmdAddr;
                r_oor     <= w_cmdOor;
                r_txShift <= w_cmdLoad;
                r_miso    <= w_cmdLoad[7];
                r_state   <= ST_DATA;
              end else begin
                r_addr <= w_addrNext;
                if (r_rw) begin
                  r_txShift <= w_dataLoad;
                  r_miso    <= w_dataLoad[7];
                end else begin
                  r_txShift <= 8'h00;
                  r_miso    <= 1'b0;
                end
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MISO       = r_miso;
  assign bus.MISO_OE    = r_misoOe;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.wr_pulse   = r_wrPulse;
  assign bus.wr_addr    = r_wrAddr;
  assign bus.wr_data    = r_wrData;
  assign bus.host_rdata = r_regs[bus.host_addr];

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a table of SPI frames plus hand-written
// abort, collision and mid-byte reset sequences.
module tb_spi_responder;

  localparam int HALF = 5;

  typedef struct {
    logic [7:0] cmd;
    int         nData;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [7:0] rx0;
    logic [7:0] rx1;
    int         nPulse;
    logic [11:0] pulse0;
    logic [11:0] pulse1;
    logic [3:0] chkAddr;
    logic [7:0] chkData;
  } vec_t;

  logic clk;
  logic rstN;
  int   testsRun;
  int   testsFailed;
  logic [11:0] pulseLog [$];
  vec_t vecs [9];

  spi_responder_if #(.ADDR_W(4)) bus ();

  spi_responder #(
    .NUM_REGS (16),
    .ADDR_W   (4),
    .ID_BYTE  (8'h5A)
  ) dut (
    .Clk     (clk),
    .Reset_n (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rstN && bus.wr_pulse) pulseLog.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [11:0] pulseAt(input int idx);
    if (pulseLog.size() > idx) return pulseLog[idx];
    return 12'hFFF;
  endfunction

  task automatic spiBits(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      bus.MOSI = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = bus.MISO;
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic csLow();
    bus.CS_N = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic csHigh();
    repeat (4) @(negedge clk);
    bus.CS_N = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic hostWrite(input logic [3:0] addr, input logic [7:0] data);
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    @(negedge clk);
    bus.host_we = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [7:0] rx;
    int startCnt;
    startCnt = pulseLog.size();
    csLow();
    spiBits(v.cmd, 8, rx);
    checkOutput($sformatf("v%0d_id", idx), {24'd0, rx}, 32'h5A);
    checkOutput($sformatf("v%0d_busy", idx), {31'd0, bus.busy}, 32'd1);
    checkOutput($sformatf("v%0d_oe", idx), {31'd0, bus.MISO_OE}, 32'd1);
    if (v.nData > 0) begin
      spiBits(v.tx0, 8, rx);
      checkOutput($sformatf("v%0d_rx0", idx), {24'd0, rx}, {24'd0, v.rx0});
    end
    if (v.nData > 1) begin
      spiBits(v.tx1, 8, rx);
      checkOutput($sformatf("v%0d_rx1", idx), {24'd0, rx}, {24'd0, v.rx1});
    end
    csHigh();
    checkOutput($sformatf("v%0d_idle", idx), {30'd0, bus.busy, bus.MISO_OE}, 32'd0);
    checkOutput($sformatf("v%0d_npulse", idx), pulseLog.size() - startCnt, v.nPulse);
    if (v.nPulse > 0) checkOutput($sformatf("v%0d_pulse0", idx), {20'd0, pulseAt(startCnt)}, {20'd0, v.pulse0});
    if (v.nPulse > 1) checkOutput($sformatf("v%0d_pulse1", idx), {20'd0, pulseAt(startCnt + 1)}, {20'd0, v.pulse1});
    bus.host_addr = v.chkAddr;
    @(negedge clk);
    checkOutput($sformatf("v%0d_reg", idx), {24'd0, bus.host_rdata}, {24'd0, v.chkData});
  endtask

  initial begin
    logic [7:0] rx;
    int startCnt;
    testsRun    = 0;
    testsFailed = 0;

    //        cmd    n  tx0    tx1    rx0    rx1    np pulse0   pulse1   addr  data
    vecs[0] = '{8'h83, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 12'h000, 12'h000, 4'h3, 8'h00};
    vecs[1] = '{8'h03, 2, 8'hAB, 8'hCD, 8'h00, 8'h00, 2, 12'h3AB, 12'h4CD, 4'h4, 8'hCD};
    vecs[2] = '{8'h83, 2, 8'h00, 8'h00, 8'hAB, 8'hCD, 0, 12'h000, 12'h000, 4'h3, 8'hAB};
    vecs[3] = '{8'h8F, 2, 8'h00, 8'h00, 8'h11, 8'h22, 0, 12'h000, 12'h000, 4'hF, 8'h11};
    vecs[4] = '{8'h20, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 12'h000, 12'h000, 4'h0, 8'h22};
    vecs[5] = '{8'hA0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 12'h000, 12'h000, 4'h0, 8'h22};
    vecs[6] = '{8'h0F, 2, 8'h5C, 8'h3D, 8'h00, 8'h00, 2, 12'hF5C, 12'h03D, 4'h0, 8'h3D};
    vecs[7] = '{8'h8F, 2, 8'h00, 8'h00, 8'h5C, 8'h3D, 0, 12'h000, 12'h000, 4'hF, 8'h5C};
    vecs[8] = '{8'h05, 1, 8'h3C, 8'h00, 8'h00, 8'h00, 1, 12'h53C, 12'h000, 4'h5, 8'h3C};

    rstN           = 1'b0;
    bus.SCLK       = 1'b0;
    bus.CS_N       = 1'b1;
    bus.MOSI       = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 4'h0;
    bus.host_wdata = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_outputs", {28'd0, bus.busy, bus.MISO_OE, bus.MISO, bus.wr_pulse}, 32'd0);
    checkOutput("rst_rdata", {24'd0, bus.host_rdata}, 32'd0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    hostWrite(4'hF, 8'h11);
    checkOutput("host_rd15", {24'd0, bus.host_rdata}, 32'h11);
    hostWrite(4'h0, 8'h22);
    checkOutput("host_rd0", {24'd0, bus.host_rdata}, 32'h22);

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Abort: write command to reg 5, five data bits, then deselect.
    startCnt = pulseLog.size();
    csLow();
    spiBits(8'h05, 8, rx);
    spiBits(8'hFF, 5, rx);
    csHigh();
    checkOutput("abort_npulse", pulseLog.size() - startCnt, 32'd0);
    checkOutput("abort_idle", {30'd0, bus.busy, bus.MISO_OE}, 32'd0);
    bus.host_addr = 4'h5;
    @(negedge clk);
    checkOutput("abort_reg5", {24'd0, bus.host_rdata}, 32'h00);
    applyStimulus(8, vecs[8]);

    // Collision: host writes 0x99 to reg 6 in the very cycle the SPI byte 0x77 lands.
    csLow();
    spiBits(8'h06, 8, rx);
    spiBits(8'h77, 7, rx);
    bus.MOSI = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.SCLK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.host_we    = 1'b1;
    bus.host_addr  = 4'h6;
    bus.host_wdata = 8'h99;
    @(negedge clk);
    bus.host_we = 1'b0;
    checkOutput("coll_pulse", {31'd0, bus.wr_pulse}, 32'd1);
    repeat (HALF - 3) @(negedge clk);
    bus.SCLK = 1'b0;
    csHigh();
    bus.host_addr = 4'h6;
    @(negedge clk);
    checkOutput("coll_reg6", {24'd0, bus.host_rdata}, 32'h77);
    checkOutput("coll_wr", {20'd0, bus.wr_addr, bus.wr_data}, 32'h677);

    // Reset asserted in the middle of a data byte.
    csLow();
    spiBits(8'h07, 8, rx);
    spiBits(8'hF0, 3, rx);
    rstN = 1'b0;
    #1;
    checkOutput("mrst_outputs", {28'd0, bus.busy, bus.MISO_OE, bus.MISO, bus.wr_pulse}, 32'd0);
    checkOutput("mrst_wr", {20'd0, bus.wr_addr, bus.wr_data}, 32'd0);
    checkOutput("mrst_reg6", {24'd0, bus.host_rdata}, 32'd0);
    bus.CS_N = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    csLow();
    spiBits(8'h86, 8, rx);
    checkOutput("post_rst_id", {24'd0, rx}, 32'h5A);
    spiBits(8'h00, 8, rx);
    checkOutput("post_rst_rd6", {24'd0, rx}, 32'h00);
    csHigh();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
